dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port, word-addressed data memory between the two load/store lanes of the dual-issue pipeline. Lane 0 always carries the older instruction and lane 1 the younger. When both lanes access memory in the same cycle, the block serialises them in program order and stalls the pipeline for one cycle. It merges or forwards same-word pairs where that is safe, so no stall is needed for them. A saturating counter records how many conflict stalls have occurred.

Parameters:
ADDR_W, 32, byte-address width; word index is addr[ADDR_W-1:2]
DATA_W, 32, data width
CNT_W, 16, width of the conflict stall counter

Ports:
clk  input  1  system clock; memory samples on negedge, arbiter on posedge
reset_n  input  1  synchronous, active-low reset
req0  input  1  lane 0 memory access request
we0  input  1  lane 0 store (1) / load (0)
addr0  input  ADDR_W  lane 0 byte address
wdata0  input  DATA_W  lane 0 store data
req1, we1, addr1, wdata1  input  1/1/ADDR_W/DATA_W  lane 1 equivalents
rdata0  output  DATA_W  lane 0 load result
rdata1  output  DATA_W  lane 1 load result
stall  output  1  hold both lanes' inputs; pipeline must not advance
mem_write  output  1  to memory write
mem_address  output  ADDR_W  to memory address
mem_write_data  output  DATA_W  to memory write_data
mem_read_data  input  DATA_W  from memory read_data (valid before next posedge after a read)
conflict_count  output  CNT_W  saturating count of conflict stall cycles

Behaviour:
- States:
  - FIRST (reset state).
  - SECOND.
- Reset values:
  - State = FIRST.
  - hold0 register = 0.
  - conflict_count = 0.
  - stall = 0.
  - Memory port outputs are combinational from the state and inputs.
- "Same word" means addr0[ADDR_W-1:2] == addr1[ADDR_W-1:2].
- FIRST, single requester: drive the memory port from that lane. stall = 0. The lane's rdata = mem_read_data. Latency is one cycle.
- FIRST, no requests: mem_write = 0, mem_address = addr0. rdata outputs are don't-care; the bench must check them only for requesting loads.
- FIRST, both request, same word, handled in one cycle with stall = 0:
  - Load/load: one read; rdata0 = rdata1 = mem_read_data.
  - Store/store: one write of wdata1, because the younger lane wins.
  - Store(0)/load(1): write wdata0; rdata1 = wdata0 (forwarded).
- FIRST, both request, any other case (different words, or load(0)/store(1) to the same word):
  - Drive lane 0 to the memory. stall = 1.
  - At posedge: hold0 <= mem_read_data, state <= SECOND, conflict_count += 1, saturating at all-ones.
- SECOND:
  - Drive lane 1 to the memory. stall = 0.
  - rdata0 = hold0. rdata1 = mem_read_data.
  - At posedge: state <= FIRST.
- In SECOND the lane inputs are guaranteed held by the pipeline. The block does not capture lane 1.
- A load after a store to a different word still reads memory, because the prior write has already landed.
- Reset asserted in SECOND: the next state is FIRST and stall drops after that edge. The memory write already issued for lane 0 is not undone.
- mem_read_data is not updated by store cycles. rdata for a store lane is don't-care.

Decomposition:
- Package dmem_pkg holds:
  - the ADDR_W, DATA_W and CNT_W defaults;
  - the state enum {FIRST, SECOND};
  - a pair_kind function or constant encoding (SINGLE, MERGE_LL, MERGE_SS, FWD_SL, CONFLICT).
- One sub-module, dmem_pair_classifier: purely combinational. Takes the two requests and returns the pair kind. Verification can test it standalone.

Test Plan:
- Lane 0 load only, addr0 = 0x10 holding 0xDEADBEEF -> same cycle mem_address = 0x10, stall = 0, rdata0 = 0xDEADBEEF.
- Lane 0 load 0x04 (=0x11111111) and lane 1 load 0x08 (=0x22222222) -> cycle 1: stall = 1, mem_address = 0x04. Cycle 2: stall = 0, rdata0 = 0x11111111, rdata1 = 0x22222222. conflict_count = 1.
- Lane 0 store 0x20 := 0xA5A5A5A5 and lane 1 load 0x20 -> no stall, rdata1 = 0xA5A5A5A5, one memory write. A later load of 0x20 returns 0xA5A5A5A5.
- Both lanes store to 0x30 with 0x1 (lane 0) and 0x2 (lane 1) -> no stall, a single write of 0x2. A later read of 0x30 returns 0x2.
- Lane 0 load 0x40 (old = 0x7) and lane 1 store 0x40 := 0x9 -> 2 cycles, rdata0 = 0x7, then memory holds 0x9.
- Conflict, then reset_n = 0 in SECOND -> after the edge, state is FIRST, stall = 0, conflict_count = 0. Also: with CNT_W = 2, force 5 conflicts -> the counter saturates at 3.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the dual-lane data-memory arbiter.
//   DEF_ADDR_W / DEF_DATA_W / DEF_CNT_W : default widths
//   state_t      : arbiter FSM states
//   pair_kind_t  : how a pair of same-cycle lane requests is serviced
//   classify_pair: maps two requests to a pair_kind_t
package dmem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic {
    FIRST,
    SECOND
  } state_t;

  typedef enum logic [2:0] {
    SINGLE,    // zero or one lane requesting
    MERGE_LL,  // load/load, same word: one read feeds both lanes
    MERGE_SS,  // store/store, same word: younger lane's data wins
    FWD_SL,    // store(0)/load(1), same word: forward lane 0 data
    CONFLICT   // needs two memory cycles
  } pair_kind_t;

  // Load(0)/store(1) to the same word cannot merge: lane 0 must see the
  // old value, so it is serialised like a different-word pair.
  function automatic pair_kind_t classify_pair(
    input logic req0,
    input logic we0,
    input logic req1,
    input logic we1,
    input logic same_word
  );
    if (!(req0 && req1)) return SINGLE;
    if (!same_word)      return CONFLICT;
    case ({we0, we1})
      2'b00:   return MERGE_LL;
      2'b11:   return MERGE_SS;
      2'b10:   return FWD_SL;
      default: return CONFLICT;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: lane-side and memory-side signals of the arbiter.
//   lane inputs : req0/we0/addr0/wdata0, req1/we1/addr1/wdata1
//   lane outputs: rdata0, rdata1, stall
//   memory side : mem_write, mem_address, mem_write_data (out), mem_read_data (in)
//   slave  modport: the arbiter
//   master modport: pipeline + memory environment
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              stall;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_read_data,
    output rdata0, rdata1, stall,
    output mem_write, mem_address, mem_write_data
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_read_data,
    input  rdata0, rdata1, stall,
    input  mem_write, mem_address, mem_write_data
  );

endinterface

// File: rtl/dmem_pair_classifier.sv
// dmem_pair_classifier: combinational classification of the two lanes'
// requests for the current cycle.
//   i_req0/i_we0/i_word0 : lane 0 request, store flag, word index
//   i_req1/i_we1/i_word1 : lane 1 request, store flag, word index
//   o_kind               : pair kind (see dmem_pkg::pair_kind_t)
module dmem_pair_classifier
  import dmem_pkg::*;
#(
  parameter int WORD_W = DEF_ADDR_W - 2
) (
  input  logic              i_req0,
  input  logic              i_we0,
  input  logic [WORD_W-1:0] i_word0,
  input  logic              i_req1,
  input  logic              i_we1,
  input  logic [WORD_W-1:0] i_word1,
  output pair_kind_t        o_kind
);

  logic w_same_word;

  assign w_same_word = (i_word0 == i_word1);
  assign o_kind      = classify_pair(i_req0, i_we0, i_req1, i_we1, w_same_word);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port word-addressed data memory between
// the two load/store lanes. Conflicting pairs are serialised in program
// order with a one-cycle stall; safe same-word pairs are merged/forwarded.
//   clk            : system clock (memory samples on negedge)
//   reset_n        : synchronous active-low reset
//   bus            : dmem_arbiter_if.slave (lane and memory signals)
//   conflict_count : saturating count of conflict stall cycles
//
// state  | meaning
// FIRST  | normal issue; conflicting pair drives lane 0 and stalls
// SECOND | second half of a conflict; drives lane 1, lane 0 data from hold
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  dmem_arbiter_if.slave     bus,
  output logic [CNT_W-1:0]  conflict_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_hold0;
  logic [CNT_W-1:0]  r_cnt;

  pair_kind_t        w_kind;
  logic              w_conflict;
  logic              w_stall;
  logic              w_mem_write;
  logic [ADDR_W-1:0] w_mem_address;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [DATA_W-1:0] w_rdata0;
  logic [DATA_W-1:0] w_rdata1;

  dmem_pair_classifier #(
    .WORD_W (ADDR_W - 2)
  ) u_classifier (
    .i_req0  (bus.req0),
    .i_we0   (bus.we0),
    .i_word0 (bus.addr0[ADDR_W-1:2]),
    .i_req1  (bus.req1),
    .i_we1   (bus.we1),
    .i_word1 (bus.addr1[ADDR_W-1:2]),
    .o_kind  (w_kind)
  );

  always_comb begin
    w_next        = r_state;
    w_conflict    = 1'b0;
    w_stall       = 1'b0;
    w_mem_write   = 1'b0;
    w_mem_address = bus.addr0;
    w_mem_wdata   = bus.wdata0;
    w_rdata0      = bus.mem_read_data;
    w_rdata1      = bus.mem_read_data;

    case (r_state)
      FIRST: begin
        case (w_kind)
          SINGLE: begin
            if (bus.req1 && !bus.req0) begin
              w_mem_write   = bus.we1;
              w_mem_address = bus.addr1;
              w_mem_wdata   = bus.wdata1;
            end else begin
              w_mem_write   = bus.req0 & bus.we0;
            end
          end
          MERGE_LL: begin
            w_mem_write = 1'b0;
          end
          MERGE_SS: begin
            w_mem_write   = 1'b1;
            w_mem_address = bus.addr1;
            w_mem_wdata   = bus.wdata1;
          end
          FWD_SL: begin
            w_mem_write = 1'b1;
            w_rdata1    = bus.wdata0;
          end
          default: begin
            w_mem_write = bus.we0;
            w_stall     = 1'b1;
            w_conflict  = 1'b1;
            w_next      = SECOND;
          end
        endcase
      end
      SECOND: begin
        w_mem_write   = bus.we1;
        w_mem_address = bus.addr1;
        w_mem_wdata   = bus.wdata1;
        w_rdata0      = r_hold0;
        w_next        = FIRST;
      end
      default: begin
        w_next = FIRST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= FIRST;
      r_hold0 <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_conflict) begin
        r_hold0 <= bus.mem_read_data;
        if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Stall is held low while reset is asserted so the pipeline is released
  // as soon as the state register returns to FIRST.
  assign bus.stall          = w_stall & reset_n;
  assign bus.mem_write      = w_mem_write;
  assign bus.mem_address    = w_mem_address;
  assign bus.mem_write_data = w_mem_wdata;
  assign bus.rdata0         = w_rdata0;
  assign bus.rdata1         = w_rdata1;
  assign conflict_count     = r_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk;
  logic        reset_n;
  logic [15:0] cnt1;
  logic [1:0]  cnt2;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mem [0:63];

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b2 ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (b1),
    .conflict_count (cnt1)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(2)) u_dut_sat (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (b2),
    .conflict_count (cnt2)
  );

  // Second instance mirrors the lane traffic; only its counter is checked.
  assign b2.req0          = b1.req0;
  assign b2.we0           = b1.we0;
  assign b2.addr0         = b1.addr0;
  assign b2.wdata0        = b1.wdata0;
  assign b2.req1          = b1.req1;
  assign b2.we1           = b1.we1;
  assign b2.addr1         = b1.addr1;
  assign b2.wdata1        = b1.wdata1;
  assign b2.mem_read_data = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word-addressed memory sampling on negedge; reads update read_data only.
  always @(negedge clk) begin
    if (b1.mem_write) mem[b1.mem_address[7:2]] <= b1.mem_write_data;
    else              b1.mem_read_data <= mem[b1.mem_address[7:2]];
  end

  typedef struct {
    string       name;
    logic        req0, we0;
    logic [31:0] addr0, wdata0;
    logic        req1, we1;
    logic [31:0] addr1, wdata1;
    logic        exp_mw;
    logic [31:0] exp_addr, exp_wd;
    logic        chk0;
    logic [31:0] exp_r0;
    logic        chk1;
    logic [31:0] exp_r1;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(string name,
                              logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
                              logic r1, logic w1, logic [31:0] a1, logic [31:0] d1,
                              logic mw, logic [31:0] ea, logic [31:0] ewd,
                              logic c0, logic [31:0] e0, logic c1, logic [31:0] e1);
    vec_t v;
    v.name = name;
    v.req0 = r0; v.we0 = w0; v.addr0 = a0; v.wdata0 = d0;
    v.req1 = r1; v.we1 = w1; v.addr1 = a1; v.wdata1 = d1;
    v.exp_mw = mw; v.exp_addr = ea; v.exp_wd = ewd;
    v.chk0 = c0; v.exp_r0 = e0; v.chk1 = c1; v.exp_r1 = e1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    @(posedge clk); #1;
    b1.req0 = r0; b1.we0 = w0; b1.addr0 = a0; b1.wdata0 = d0;
    b1.req1 = r1; b1.we1 = w1; b1.addr1 = a1; b1.wdata1 = d1;
  endtask

  task automatic hold_cycle();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    sample();
  endtask

  task automatic conflict_ll();
    drive(1, 0, 32'h04, 32'h0, 1, 0, 32'h08, 32'h0);
    sample();
    hold_cycle();
    sample();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + i;
    mem[32'h10 >> 2] = 32'hDEADBEEF;
    mem[32'h04 >> 2] = 32'h11111111;
    mem[32'h08 >> 2] = 32'h22222222;
    mem[32'h40 >> 2] = 32'h00000007;

    //                name      r0 w0 a0     d0            r1 w1 a1     d1     mw ea     ewd           c0 e0            c1 e1
    vecs[0] = mk("ld0_only",   1, 0, 32'h10, 32'h0,        0, 0, 32'h0, 32'h0, 0, 32'h10, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0);
    vecs[1] = mk("ld1_only",   0, 0, 32'h0,  32'h0,        1, 0, 32'h04, 32'h0, 0, 32'h04, 32'h0,       0, 32'h0,        1, 32'h11111111);
    vecs[2] = mk("fwd_sl",     1, 1, 32'h20, 32'hA5A5A5A5, 1, 0, 32'h20, 32'h0, 1, 32'h20, 32'hA5A5A5A5, 0, 32'h0,       1, 32'hA5A5A5A5);
    vecs[3] = mk("ld_after_fwd", 1, 0, 32'h20, 32'h0,      0, 0, 32'h0, 32'h0, 0, 32'h20, 32'h0,        1, 32'hA5A5A5A5, 0, 32'h0);
    vecs[4] = mk("merge_ss",   1, 1, 32'h30, 32'h1,        1, 1, 32'h30, 32'h2, 1, 32'h30, 32'h2,       0, 32'h0,        0, 32'h0);
    vecs[5] = mk("ld_after_ss", 0, 0, 32'h0, 32'h0,        1, 0, 32'h30, 32'h0, 0, 32'h30, 32'h0,       0, 32'h0,        1, 32'h2);
    vecs[6] = mk("merge_ll",   1, 0, 32'h10, 32'h0,        1, 0, 32'h12, 32'h0, 0, 32'h10, 32'h0,       1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    vecs[7] = mk("st0_only",   1, 1, 32'h50, 32'h55,       0, 0, 32'h0, 32'h0, 1, 32'h50, 32'h55,       0, 32'h0,        0, 32'h0);
    vecs[8] = mk("st1_only",   0, 0, 32'h0,  32'h0,        1, 1, 32'h54, 32'h66, 1, 32'h54, 32'h66,     0, 32'h0,        0, 32'h0);
    vecs[9] = mk("ld_st_diff", 1, 0, 32'h50, 32'h0,        0, 0, 32'h14, 32'h0, 0, 32'h50, 32'h0,       1, 32'h55,       0, 32'h0);

    reset_n = 1'b0;
    b1.req0 = 0; b1.we0 = 0; b1.addr0 = 32'h14; b1.wdata0 = 0;
    b1.req1 = 0; b1.we1 = 0; b1.addr1 = 0;     b1.wdata1 = 0;
    repeat (2) @(posedge clk);
    sample();
    chk("rst_cnt", 32'(cnt1), 32'h0);
    chk("rst_stall", 32'(b1.stall), 32'h0);
    chk("rst_idle_mw", 32'(b1.mem_write), 32'h0);
    chk("rst_idle_addr", b1.mem_address, 32'h14);
    hold_cycle();
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].req0, vecs[i].we0, vecs[i].addr0, vecs[i].wdata0,
            vecs[i].req1, vecs[i].we1, vecs[i].addr1, vecs[i].wdata1);
      sample();
      chk({vecs[i].name, "_stall"}, 32'(b1.stall), 32'h0);
      chk({vecs[i].name, "_mw"}, 32'(b1.mem_write), 32'(vecs[i].exp_mw));
      chk({vecs[i].name, "_addr"}, {b1.mem_address[31:2], 2'b00}, vecs[i].exp_addr);
      if (vecs[i].exp_mw) chk({vecs[i].name, "_wd"}, b1.mem_write_data, vecs[i].exp_wd);
      if (vecs[i].chk0)   chk({vecs[i].name, "_r0"}, b1.rdata0, vecs[i].exp_r0);
      if (vecs[i].chk1)   chk({vecs[i].name, "_r1"}, b1.rdata1, vecs[i].exp_r1);
    end

    // Conflict load/load, different words.
    drive(1, 0, 32'h04, 32'h0, 1, 0, 32'h08, 32'h0);
    sample();
    chk("cll_c1_stall", 32'(b1.stall), 32'h1);
    chk("cll_c1_addr", b1.mem_address, 32'h04);
    chk("cll_c1_mw", 32'(b1.mem_write), 32'h0);
    hold_cycle();
    sample();
    chk("cll_c2_stall", 32'(b1.stall), 32'h0);
    chk("cll_c2_addr", b1.mem_address, 32'h08);
    chk("cll_c2_r0", b1.rdata0, 32'h11111111);
    chk("cll_c2_r1", b1.rdata1, 32'h22222222);
    chk("cll_cnt", 32'(cnt1), 32'h1);
    idle();
    chk("idle_stall", 32'(b1.stall), 32'h0);
    chk("idle_cnt", 32'(cnt1), 32'h1);

    // Load(0)/store(1) same word: serialised, lane 0 sees old value.
    drive(1, 0, 32'h40, 32'h0, 1, 1, 32'h40, 32'h9);
    sample();
    chk("cls_c1_stall", 32'(b1.stall), 32'h1);
    chk("cls_c1_mw", 32'(b1.mem_write), 32'h0);
    chk("cls_c1_addr", b1.mem_address, 32'h40);
    hold_cycle();
    sample();
    chk("cls_c2_stall", 32'(b1.stall), 32'h0);
    chk("cls_c2_mw", 32'(b1.mem_write), 32'h1);
    chk("cls_c2_wd", b1.mem_write_data, 32'h9);
    chk("cls_c2_r0", b1.rdata0, 32'h7);
    chk("cls_cnt", 32'(cnt1), 32'h2);
    drive(1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0);
    sample();
    chk("cls_reread", b1.rdata0, 32'h9);

    // Store/store different words.
    drive(1, 1, 32'h60, 32'hAA, 1, 1, 32'h64, 32'hBB);
    sample();
    chk("css_c1_stall", 32'(b1.stall), 32'h1);
    chk("css_c1_mw", 32'(b1.mem_write), 32'h1);
    chk("css_c1_addr", b1.mem_address, 32'h60);
    chk("css_c1_wd", b1.mem_write_data, 32'hAA);
    hold_cycle();
    sample();
    chk("css_c2_addr", b1.mem_address, 32'h64);
    chk("css_c2_wd", b1.mem_write_data, 32'hBB);
    drive(1, 0, 32'h60, 32'h0, 0, 0, 32'h0, 32'h0);
    sample();
    chk("css_rd60", b1.rdata0, 32'hAA);
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h64, 32'h0);
    sample();
    chk("css_rd64", b1.rdata1, 32'hBB);
    chk("cnt_after3", 32'(cnt1), 32'h3);
    chk("sat_after3", 32'(cnt2), 32'h3);

    // Two more conflicts: 16-bit counter keeps counting, 2-bit saturates.
    conflict_ll();
    conflict_ll();
    idle();
    chk("cnt_after5", 32'(cnt1), 32'h5);
    chk("sat_after5", 32'(cnt2), 32'h3);

    // Reset asserted while in SECOND, lane inputs still held.
    drive(1, 0, 32'h04, 32'h0, 1, 0, 32'h08, 32'h0);
    sample();
    chk("rs_c1_stall", 32'(b1.stall), 32'h1);
    hold_cycle();
    reset_n = 1'b0;
    sample();
    chk("rs_second_addr", b1.mem_address, 32'h08);
    hold_cycle();
    sample();
    chk("rs_after_stall", 32'(b1.stall), 32'h0);
    chk("rs_after_addr", b1.mem_address, 32'h04);
    chk("rs_after_cnt", 32'(cnt1), 32'h0);
    chk("rs_after_sat", 32'(cnt2), 32'h0);
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    reset_n = 1'b1;
    idle();
    chk("post_rst_stall", 32'(b1.stall), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
